// File: rtl/ccu_ctrl_snoop_collector.sv
// Snoop-round collector for the CCU read path: gathers CR responses, hands the
// snoop unit its operation, then forwards one port's CD line and drains the rest.

package ccu_ctrl_snoop_collector_pkg;
    typedef enum logic {
        READ_SNP_DATA      = 1'b0,
        SEND_INVALID_ACK_R = 1'b1
    } su_op_e;
endpackage

module ccu_ctrl_snoop_collector
    import ccu_ctrl_snoop_collector_pkg::*;
#(
    parameter int unsigned NoMstPorts      = 4,
    parameter int unsigned AxiDataWidth    = 64,
    parameter int unsigned DcacheLineWidth = 128,
    localparam int unsigned MstIdxBits     = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [NoMstPorts-1:0]          snoop_mask_i,
    output logic                           busy_o,
    input  logic [NoMstPorts-1:0]          cr_valid_i,
    output logic [NoMstPorts-1:0]          cr_ready_o,
    input  logic [5*NoMstPorts-1:0]        cr_resp_i,
    input  logic [NoMstPorts-1:0]          cd_valid_i,
    output logic [NoMstPorts-1:0]          cd_ready_o,
    input  logic [AxiDataWidth*NoMstPorts-1:0] cd_data_i,
    input  logic [NoMstPorts-1:0]          cd_last_i,
    output logic [AxiDataWidth-1:0]        cd_o,
    output logic                           cd_handshake_o,
    input  logic                           cd_fifo_full_i,
    output logic                           su_valid_o,
    input  logic                           su_ready_i,
    output su_op_e                         su_op_o,
    output logic                           shared_o,
    output logic                           dirty_o,
    output logic                           err_o
);

    typedef enum logic [1:0] {StIdle, StCollectCr, StDispatch, StXfer} state_e;

    state_e                  state_q, state_d;
    logic [NoMstPorts-1:0]   pending_q, pending_d;
    logic [NoMstPorts-1:0]   data_mask_q, data_mask_d;
    logic [NoMstPorts-1:0]   done_q, done_d;
    logic [MstIdxBits-1:0]   sel_q, sel_d;
    logic                    shared_q, shared_d;
    logic                    dirty_q, dirty_d;
    logic                    err_q, err_d;

    logic [MstIdxBits-1:0]   lowest_idx;
    logic [NoMstPorts-1:0]   cr_hs;
    logic                    port_hs;
    logic [AxiDataWidth-1:0] cd_data_arr [NoMstPorts];

    // WasUnique is not needed for the merge.
    logic unused_resp;
    assign unused_resp = ^cr_resp_i;

    // The line must be a whole number of beats; cd_last_i alone ends a transfer.
    assert property (@(posedge clk_i) (DcacheLineWidth % AxiDataWidth) == 0);

    assign busy_o   = (state_q != StIdle);
    assign shared_o = shared_q;
    assign dirty_o  = dirty_q;
    assign err_o    = err_q;

    // Unpack per-port CD data and find the lowest data-carrying port.
    always_comb begin
        lowest_idx = '0;
        for (int i = 0; i < int'(NoMstPorts); i++) begin
            cd_data_arr[i] = cd_data_i[i*AxiDataWidth +: AxiDataWidth];
        end
        for (int i = int'(NoMstPorts) - 1; i >= 0; i--) begin
            if (data_mask_q[i]) lowest_idx = MstIdxBits'(i);
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        data_mask_d    = data_mask_q;
        done_d         = done_q;
        sel_d          = sel_q;
        shared_d       = shared_q;
        dirty_d        = dirty_q;
        err_d          = err_q;
        cr_hs          = '0;
        port_hs        = 1'b0;
        cr_ready_o     = '0;
        cd_ready_o     = '0;
        cd_o           = '0;
        cd_handshake_o = 1'b0;
        su_valid_o     = 1'b0;
        su_op_o        = SEND_INVALID_ACK_R;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    pending_d   = snoop_mask_i;
                    data_mask_d = '0;
                    done_d      = '0;
                    shared_d    = 1'b0;
                    dirty_d     = 1'b0;
                    err_d       = 1'b0;
                    state_d     = (snoop_mask_i != '0) ? StCollectCr : StDispatch;
                end
            end
            StCollectCr: begin
                cr_ready_o = pending_q;
                cr_hs      = pending_q & cr_valid_i;
                for (int i = 0; i < int'(NoMstPorts); i++) begin
                    if (cr_hs[i]) begin
                        data_mask_d[i] = data_mask_q[i] | cr_resp_i[5*i];
                        shared_d       = shared_d | cr_resp_i[5*i+3];
                        dirty_d        = dirty_d | (cr_resp_i[5*i+2] & cr_resp_i[5*i]);
                        err_d          = err_d | cr_resp_i[5*i+1];
                    end
                end
                pending_d = pending_q & ~cr_hs;
                if (pending_d == '0) state_d = StDispatch;
            end
            StDispatch: begin
                su_valid_o = 1'b1;
                su_op_o    = (data_mask_q != '0) ? READ_SNP_DATA : SEND_INVALID_ACK_R;
                sel_d      = lowest_idx;
                if (su_ready_i) state_d = (data_mask_q != '0) ? StXfer : StIdle;
            end
            StXfer: begin
                cd_o = cd_data_arr[sel_q];
                for (int i = 0; i < int'(NoMstPorts); i++) begin
                    port_hs = 1'b0;
                    if (data_mask_q[i] && !done_q[i]) begin
                        if (MstIdxBits'(i) == sel_q) begin
                            // Selected port follows FIFO backpressure; others drain freely.
                            cd_ready_o[i]  = !cd_fifo_full_i;
                            port_hs        = cd_valid_i[i] & !cd_fifo_full_i;
                            cd_handshake_o = port_hs;
                        end else begin
                            cd_ready_o[i] = 1'b1;
                            port_hs       = cd_valid_i[i];
                        end
                    end
                    if (port_hs && cd_last_i[i]) done_d[i] = 1'b1;
                end
                if ((data_mask_q & ~done_d) == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A reset abandons the round at once: no handshakes in the reset cycle.
        if (rst_i) begin
            cr_ready_o     = '0;
            cd_ready_o     = '0;
            cd_handshake_o = 1'b0;
            su_valid_o     = 1'b0;
        end
    end

    // State and round registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            data_mask_q <= '0;
            done_q      <= '0;
            sel_q       <= '0;
            shared_q    <= 1'b0;
            dirty_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            data_mask_q <= data_mask_d;
            done_q      <= done_d;
            sel_q       <= sel_d;
            shared_q    <= shared_d;
            dirty_q     <= dirty_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ccu_ctrl_snoop_collector.sv
// Directed bench for ccu_ctrl_snoop_collector.
module tb_ccu_ctrl_snoop_collector;
    import ccu_ctrl_snoop_collector_pkg::*;

    localparam int N = 4;
    localparam int W = 64;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           start_i;
    logic [N-1:0]   snoop_mask_i;
    logic           busy_o;
    logic [N-1:0]   cr_valid_i;
    logic [N-1:0]   cr_ready_o;
    logic [5*N-1:0] cr_resp_i;
    logic [N-1:0]   cd_valid_i;
    logic [N-1:0]   cd_ready_o;
    logic [W*N-1:0] cd_data_i;
    logic [N-1:0]   cd_last_i;
    logic [W-1:0]   cd_o;
    logic           cd_handshake_o;
    logic           cd_fifo_full_i;
    logic           su_valid_o;
    logic           su_ready_i;
    su_op_e         su_op_o;
    logic           shared_o;
    logic           dirty_o;
    logic           err_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] fwd_q [$];

    always #5 clk_i = ~clk_i;

    ccu_ctrl_snoop_collector #(
        .NoMstPorts      (N),
        .AxiDataWidth    (W),
        .DcacheLineWidth (128)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .snoop_mask_i   (snoop_mask_i),
        .busy_o         (busy_o),
        .cr_valid_i     (cr_valid_i),
        .cr_ready_o     (cr_ready_o),
        .cr_resp_i      (cr_resp_i),
        .cd_valid_i     (cd_valid_i),
        .cd_ready_o     (cd_ready_o),
        .cd_data_i      (cd_data_i),
        .cd_last_i      (cd_last_i),
        .cd_o           (cd_o),
        .cd_handshake_o (cd_handshake_o),
        .cd_fifo_full_i (cd_fifo_full_i),
        .su_valid_o     (su_valid_o),
        .su_ready_i     (su_ready_i),
        .su_op_o        (su_op_o),
        .shared_o       (shared_o),
        .dirty_o        (dirty_o),
        .err_o          (err_o)
    );

    // Record every beat pushed into the snoop unit FIFO.
    always @(posedge clk_i) begin
        if (cd_handshake_o) fwd_q.push_back(cd_o);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_resp(input int p, input logic [4:0] v);
        cr_resp_i[5*p +: 5] = v;
    endtask

    task automatic set_beat(input int p, input logic [W-1:0] d, input logic last);
        cd_valid_i[p]      = 1'b1;
        cd_data_i[W*p +: W] = d;
        cd_last_i[p]       = last;
    endtask

    task automatic clear_cd();
        cd_valid_i = '0;
        cd_last_i  = '0;
        cd_data_i  = '0;
    endtask

    task automatic start_round(input logic [N-1:0] mask);
        start_i      = 1'b1;
        snoop_mask_i = mask;
        tick();
        start_i      = 1'b0;
        snoop_mask_i = '0;
        settle();
    endtask

    task automatic check_fwd(input string tag, input logic [W-1:0] d0, input logic [W-1:0] d1);
        check({tag, "_cnt"}, 64'(fwd_q.size()), 64'd2);
        if (fwd_q.size() == 2) begin
            check({tag, "_b0"}, fwd_q[0], d0);
            check({tag, "_b1"}, fwd_q[1], d1);
        end
    endtask

    // Port 2 round with resp 0b01101 and port 1 resp 0, left in XFER.
    task automatic port2_to_xfer(input string tag);
        start_round(4'b0110);
        check({tag, "_cr_ready"}, 64'(cr_ready_o), 64'b0110);
        set_resp(1, 5'b00000);
        set_resp(2, 5'b01101);
        cr_valid_i = 4'b0110;
        tick();
        cr_valid_i = '0;
        settle();
        check({tag, "_su_valid"}, 64'(su_valid_o), 64'd1);
        check({tag, "_op"}, 64'(su_op_o), 64'(READ_SNP_DATA));
        check({tag, "_shared"}, 64'(shared_o), 64'd1);
        check({tag, "_dirty"}, 64'(dirty_o), 64'd1);
        su_ready_i = 1'b1;
        tick();
        su_ready_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; snoop_mask_i = '0; cr_valid_i = '0; cr_resp_i = '0;
        cd_fifo_full_i = 1'b0; su_ready_i = 1'b0;
        clear_cd();
        tick();
        tick();
        rst_i = 1'b0;
        settle();
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_su_valid", 64'(su_valid_o), 64'd0);
        check("rst_su_op", 64'(su_op_o), 64'(SEND_INVALID_ACK_R));
        check("rst_flags", 64'({shared_o, dirty_o, err_o}), 64'd0);
        check("rst_readies", 64'({cr_ready_o, cd_ready_o}), 64'd0);
        check("rst_cd", 64'({cd_handshake_o, cd_o}), 64'd0);

        // Empty mask: straight to dispatch with an invalid ack.
        fwd_q.delete();
        start_round(4'b0000);
        check("s1_su_valid", 64'(su_valid_o), 64'd1);
        check("s1_op", 64'(su_op_o), 64'(SEND_INVALID_ACK_R));
        check("s1_cd_ready", 64'(cd_ready_o), 64'd0);
        su_ready_i = 1'b1;
        tick();
        su_ready_i = 1'b0;
        settle();
        check("s1_busy_end", 64'(busy_o), 64'd0);
        check("s1_su_valid_end", 64'(su_valid_o), 64'd0);
        check("s1_fwd", 64'(fwd_q.size()), 64'd0);

        // Single data port, two beats.
        fwd_q.delete();
        port2_to_xfer("s2");
        set_beat(2, 64'hA, 1'b0);
        settle();
        check("s2_cd_ready", 64'(cd_ready_o), 64'b0100);
        check("s2_hs0", 64'(cd_handshake_o), 64'd1);
        check("s2_cd0", cd_o, 64'hA);
        tick();
        set_beat(2, 64'hB, 1'b1);
        settle();
        check("s2_cd1", cd_o, 64'hB);
        tick();
        clear_cd();
        settle();
        check("s2_busy_end", 64'(busy_o), 64'd0);
        check("s2_hold", 64'({shared_o, dirty_o}), 64'b11);
        check_fwd("s2_fwd", 64'hA, 64'hB);

        // Two data ports: lowest forwarded, the other drained.
        fwd_q.delete();
        start_round(4'b1010);
        set_resp(1, 5'b00001);
        set_resp(3, 5'b00001);
        cr_valid_i = 4'b1010;
        tick();
        cr_valid_i = '0;
        settle();
        check("s3_op", 64'(su_op_o), 64'(READ_SNP_DATA));
        check("s3_flags", 64'({shared_o, dirty_o, err_o}), 64'd0);
        su_ready_i = 1'b1;
        tick();
        su_ready_i = 1'b0;
        set_beat(1, 64'h11, 1'b0);
        set_beat(3, 64'h33, 1'b0);
        settle();
        check("s3_cd_ready", 64'(cd_ready_o), 64'b1010);
        check("s3_cd0", cd_o, 64'h11);
        tick();
        set_beat(1, 64'h12, 1'b1);
        set_beat(3, 64'h34, 1'b0);
        tick();
        cd_valid_i[1] = 1'b0;
        set_beat(3, 64'h35, 1'b1);
        settle();
        check("s3_busy_mid", 64'(busy_o), 64'd1);
        check("s3_cd_ready_drain", 64'(cd_ready_o), 64'b1000);
        check("s3_hs_drain", 64'(cd_handshake_o), 64'd0);
        tick();
        clear_cd();
        settle();
        check("s3_busy_end", 64'(busy_o), 64'd0);
        check_fwd("s3_fwd", 64'h11, 64'h12);

        // FIFO full for three cycles mid-transfer.
        fwd_q.delete();
        port2_to_xfer("s4");
        set_beat(2, 64'hA, 1'b0);
        tick();
        set_beat(2, 64'hB, 1'b1);
        cd_fifo_full_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("s4_full_ready", 64'(cd_ready_o[2]), 64'd0);
            check("s4_full_hs", 64'(cd_handshake_o), 64'd0);
            tick();
        end
        cd_fifo_full_i = 1'b0;
        settle();
        check("s4_resume_hs", 64'(cd_handshake_o), 64'd1);
        tick();
        clear_cd();
        settle();
        check("s4_busy_end", 64'(busy_o), 64'd0);
        check_fwd("s4_fwd", 64'hA, 64'hB);

        // All CRs in one cycle with an error; start_i ignored during XFER.
        fwd_q.delete();
        start_round(4'b1111);
        set_resp(0, 5'b00010);
        set_resp(1, 5'b00000);
        set_resp(2, 5'b00000);
        set_resp(3, 5'b00001);
        cr_valid_i = 4'b1111;
        tick();
        cr_valid_i = '0;
        settle();
        check("s5_su_valid", 64'(su_valid_o), 64'd1);
        check("s5_err", 64'(err_o), 64'd1);
        check("s5_dirty", 64'(dirty_o), 64'd0);
        su_ready_i = 1'b1;
        tick();
        su_ready_i = 1'b0;
        start_i = 1'b1;
        snoop_mask_i = 4'b0001;
        set_beat(3, 64'h55, 1'b0);
        settle();
        check("s5_cd_ready", 64'(cd_ready_o), 64'b1000);
        tick();
        start_i = 1'b0;
        snoop_mask_i = '0;
        set_beat(3, 64'h56, 1'b1);
        settle();
        check("s5_busy_mid", 64'(busy_o), 64'd1);
        check("s5_err_mid", 64'(err_o), 64'd1);
        tick();
        clear_cd();
        settle();
        check("s5_busy_end", 64'(busy_o), 64'd0);
        check("s5_err_hold", 64'(err_o), 64'd1);
        check_fwd("s5_fwd", 64'h55, 64'h56);

        // Reset during XFER, then a clean round.
        start_round(4'b0100);
        set_resp(2, 5'b00001);
        cr_valid_i = 4'b0100;
        tick();
        cr_valid_i = '0;
        su_ready_i = 1'b1;
        tick();
        su_ready_i = 1'b0;
        set_beat(2, 64'h77, 1'b0);
        settle();
        check("s6_hs_pre", 64'(cd_handshake_o), 64'd1);
        rst_i = 1'b1;
        settle();
        check("s6_hs_in_rst", 64'(cd_handshake_o), 64'd0);
        tick();
        rst_i = 1'b0;
        settle();
        check("s6_busy", 64'(busy_o), 64'd0);
        check("s6_readies", 64'({cr_ready_o, cd_ready_o}), 64'd0);
        check("s6_su_valid", 64'(su_valid_o), 64'd0);
        check("s6_err", 64'(err_o), 64'd0);
        clear_cd();
        fwd_q.delete();
        start_round(4'b0001);
        set_resp(0, 5'b01001);
        cr_valid_i = 4'b0001;
        tick();
        cr_valid_i = '0;
        settle();
        check("s6_op", 64'(su_op_o), 64'(READ_SNP_DATA));
        check("s6_shared", 64'(shared_o), 64'd1);
        su_ready_i = 1'b1;
        tick();
        su_ready_i = 1'b0;
        set_beat(0, 64'h88, 1'b0);
        tick();
        set_beat(0, 64'h99, 1'b1);
        tick();
        clear_cd();
        settle();
        check("s6_busy_end", 64'(busy_o), 64'd0);
        check_fwd("s6_fwd", 64'h88, 64'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
